// File: rtl/layer_header_fetch.sv
// Scans the per-layer header register file on each start and forwards the
// headers of enabled layers downstream over a valid/ready handshake.
module layer_header_fetch #(
    parameter int NUM_LAYERS = 32,
    parameter int LAYER_W    = 5,
    parameter int ENABLE_BIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [LAYER_W-1:0] pipe_layer,
    input  logic [127:0]       pipe_allRegisters,
    output logic               hdr_valid,
    input  logic               hdr_ready,
    output logic [127:0]       hdr_data,
    output logic [LAYER_W-1:0] hdr_layer,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {IDLE, READ, EVAL, OUT, FIN} state_t;

    localparam logic [LAYER_W-1:0] LAST = LAYER_W'(NUM_LAYERS - 1);

    state_t             state, state_nxt;
    logic [LAYER_W-1:0] idx, idx_nxt;
    logic               hdr_valid_nxt;
    logic               load_hdr;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        hdr_valid_nxt = hdr_valid;
        load_hdr      = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (start) state_nxt = READ;
            end
            READ: state_nxt = EVAL;
            EVAL: begin
                // Read data for idx arrives one cycle after the address, i.e. now.
                if (pipe_allRegisters[ENABLE_BIT]) begin
                    load_hdr      = 1'b1;
                    hdr_valid_nxt = 1'b1;
                    state_nxt     = OUT;
                end else if (idx == LAST) begin
                    state_nxt = FIN;
                end else begin
                    idx_nxt   = idx + LAYER_W'(1);
                    state_nxt = READ;
                end
            end
            OUT: begin
                if (hdr_valid && hdr_ready) begin
                    hdr_valid_nxt = 1'b0;
                    if (idx == LAST) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx + LAYER_W'(1);
                        state_nxt = READ;
                    end
                end
            end
            FIN: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
        // Abort overrides everything; the last captured payload is kept.
        if (abort) begin
            state_nxt     = IDLE;
            idx_nxt       = '0;
            hdr_valid_nxt = 1'b0;
            load_hdr      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            hdr_valid <= 1'b0;
            hdr_data  <= '0;
            hdr_layer <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            hdr_valid <= hdr_valid_nxt;
            if (load_hdr) begin
                hdr_data  <= pipe_allRegisters;
                hdr_layer <= idx;
            end
        end
    end

    assign pipe_layer = idx;
    assign busy       = (state == READ) || (state == EVAL) || (state == OUT);
    assign done       = (state == FIN);

endmodule

// File: doc/layer_header_fetch.md
# layer_header_fetch

Pipeline-side scanner for the per-layer header register file. On each `start` it walks layer addresses 0..NUM_LAYERS-1 over the register file's pipeline read port. It tests each 128-bit header's enable bit and forwards only enabled headers downstream over a valid/ready handshake. It sits between the layer register storage and the layer-composition stages, and signals scan completion with `done`.

## Interface
- NUM_LAYERS, default 32: layers scanned per pass, 2..32.
- LAYER_W, default 5: width of layer index, must satisfy 2^LAYER_W >= NUM_LAYERS.
- ENABLE_BIT, default 0: bit of header word 0 (header bits [15:0]) that marks a layer enabled.
- clk, input, 1: pipeline clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a scan; sampled only in IDLE.
- abort, input, 1: synchronous cancel of the current scan.
- pipe_layer, output, LAYER_W: read address to the register file pipeline port (registered).
- pipe_allRegisters, input, 128: header data, valid exactly one cycle after `pipe_layer` is presented.
- hdr_valid, output, 1: `hdr_data`/`hdr_layer` hold an enabled header.
- hdr_ready, input, 1: downstream accepts header when high with `hdr_valid`.
- hdr_data, output, 128: captured header of the enabled layer.
- hdr_layer, output, LAYER_W: index of the layer in `hdr_data`.
- busy, output, 1: scan in progress (READ, EVAL, OUT).
- done, output, 1: one-cycle pulse when a scan completes normally.

## Operation
- States: IDLE, READ, EVAL, OUT, FIN. Internal counter `idx` (LAYER_W bits); `pipe_layer` = `idx` at all times.
- IDLE: `idx`=0. If `start`, go to READ.
- READ: address `idx` is on `pipe_layer`; unconditionally go to EVAL.
- EVAL: sample `pipe_allRegisters`.
  - If bit ENABLE_BIT is 1: load `hdr_data` with the sampled header and `hdr_layer` with `idx`, set `hdr_valid`, and go to OUT.
  - Else, if `idx`==NUM_LAYERS-1, go to FIN.
  - Else increment `idx` and go to READ.
- OUT: hold `hdr_valid`, `hdr_data`, `hdr_layer` and `idx` stable. On `hdr_valid && hdr_ready`:
  - clear `hdr_valid`;
  - if `idx`==NUM_LAYERS-1, go to FIN;
  - else increment `idx` and go to READ.
- FIN: `done`=1 for this cycle only, `idx`←0, go to IDLE.
- `abort` (any state other than IDLE) has priority over all other transitions. Next cycle: IDLE, `idx`=0, `hdr_valid`=0, no `done` pulse. `hdr_data`/`hdr_layer` keep their last values.
- `start` outside IDLE is ignored, including in FIN. `start` and `abort` together in IDLE: `abort` wins, stay IDLE.
- `idx` never exceeds NUM_LAYERS-1; no wrap-around within a scan.
- `busy` and `done` are decoded from the registered state: `busy` is high in READ/EVAL/OUT, `done` is high in FIN.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `idx`=0, `pipe_layer`=0, `hdr_valid`=0, `hdr_data`=0, `hdr_layer`=0, `busy`=0, `done`=0. Reset mid-scan discards the scan; no `done`.
- `start` sampled at edge t: READ in cycle t+1 with `pipe_layer`=0, EVAL in t+2.
- Each layer costs 2 cycles (READ+EVAL), plus cycles spent in OUT for enabled layers.
- Enabled layer k with `hdr_ready` held high:
  - `hdr_valid` rises in cycle t+2k+3 and is accepted in that cycle;
  - each accepted header adds 1 cycle to every later event.
- All layers disabled, NUM_LAYERS=32: FIN (`done`=1) in cycle t+65.
- `hdr_valid` never deasserts without acceptance, except on `abort` or reset. Payload stays stable while `hdr_valid`=1 and `hdr_ready`=0.
- `hdr_ready` is ignored when `hdr_valid`=0.
- Headers are emitted in strictly increasing `hdr_layer` order, at most one per scan per layer.

## Test plan
- All 32 layers disabled, `start` at edge t -> `hdr_valid` never asserted; `done` pulses exactly in cycle t+65; `busy` high in t+1..t+64.
- Layers 3 and 17 enabled (distinct 128-bit patterns), `hdr_ready`=1 -> two handshakes, `hdr_layer`=3 then 17, `hdr_data` matching the stored patterns; `done` in cycle t+67.
- Layer 5 enabled, `hdr_ready` low for 10 cycles after `hdr_valid` rises -> `hdr_valid`, `hdr_data`, `hdr_layer`=5 and `pipe_layer`=5 stable throughout; scan resumes at layer 6 the cycle after acceptance.
- `abort` asserted while in OUT on layer 9 -> next cycle IDLE, `hdr_valid`=0, `pipe_layer`=0; no `done`. A following `start` rescans from layer 0.
- `start` pulsed during a scan and during FIN -> ignored, exactly one `done` pulse. `rst_n` dropped mid-scan -> all outputs at reset values immediately, without waiting for a clock edge.
- Only layer 31 enabled -> header accepted with `hdr_layer`=31, then `done` in the following cycle, then IDLE.
